// File: rtl/i2s_dsp_pkg.sv
// Shared widths, receive FSM states and the word-assembly helper for the
// I2S DSP/TDM receive channel.
package i2s_dsp_pkg;

  localparam int I2S_WORD_W    = 32;
  localparam int I2S_BITCNT_W  = 5;
  localparam int I2S_WORDCNT_W = 4;
  localparam int I2S_OFFSET_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FS,
    ST_OFFSET,
    ST_RUNNING
  } rx_state_e;

  // Inserts one serial bit into a partially assembled word. Index 0 starts a
  // fresh word, so bits left over from the previous word never leak through.
  function automatic logic [I2S_WORD_W-1:0] sr_insert(
    input logic [I2S_WORD_W-1:0]   cur,
    input logic [I2S_BITCNT_W-1:0] idx,
    input logic                    bit_in,
    input logic                    lsb_first
  );
    logic [I2S_WORD_W-1:0] base;
    base = (idx == '0) ? '0 : cur;
    if (lsb_first) base[idx] = bit_in;
    else           base = {base[I2S_WORD_W-2:0], bit_in};
    return base;
  endfunction

endpackage

// File: rtl/i2s_rx_word_buf.sv
// Two-entry word FIFO that can accept zero, one or two words per cycle, so a
// ch0/ch1 pair always lands together. Entry 0 is always the head.
module i2s_rx_word_buf
  import i2s_dsp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            wr_num,
  input  logic [I2S_WORD_W-1:0] wr_data0,
  input  logic [I2S_WORD_W-1:0] wr_data1,
  input  logic                  rd_en,
  output logic [I2S_WORD_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            free_cnt
);

  logic [I2S_WORD_W-1:0] entry0, entry1, entry0_n, entry1_n;
  logic [1:0]            count, count_n, remain;
  logic                  pop;

  assign pop    = rd_en && (count != 2'd0);
  assign remain = count - {1'b0, pop};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    entry0_n = entry0;
    entry1_n = entry1;
    if (pop) entry0_n = entry1;
    if (wr_num != 2'd0) begin
      if (remain == 2'd0) entry0_n = wr_data0;
      else                entry1_n = wr_data0;
    end
    if (wr_num == 2'd2) entry1_n = wr_data1;
    count_n = remain + wr_num;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || flush) count <= 2'd0;
    else              count <= count_n;
  end

  // NOTE: the storage needs no reset; the occupancy count alone defines validity.
  always_ff @(posedge clk) begin
    entry0 <= entry0_n;
    entry1 <= entry1_n;
  end

  assign rd_valid = (count != 2'd0);
  assign rd_data  = rd_valid ? entry0 : '0;
  assign free_cnt = 2'd2 - count;

endmodule

// File: rtl/i2s_rx_dsp_channel.sv
// DSP/TDM receive channel: waits for a frame-sync edge, skips the bit offset,
// deserialises one or two lines and pushes the words into a small FIFO.
module i2s_rx_dsp_channel
  import i2s_dsp_pkg::*;
(
  input  logic                     sck_i,
  input  logic                     rst_i,
  input  logic                     i2s_ch0_i,
  input  logic                     i2s_ch1_i,
  input  logic                     ws_i,
  output logic [I2S_WORD_W-1:0]    fifo_data_o,
  output logic                     fifo_data_valid_o,
  input  logic                     fifo_data_ready_i,
  output logic                     fifo_err_o,
  input  logic                     cfg_en_i,
  input  logic                     cfg_2ch_i,
  input  logic [I2S_BITCNT_W-1:0]  cfg_num_bits_i,
  input  logic [I2S_WORDCNT_W-1:0] cfg_num_word_i,
  input  logic                     cfg_lsb_first_i,
  input  logic [I2S_OFFSET_W-1:0]  cfg_dsp_offset_i
);

  rx_state_e                state, state_n;
  logic                     ws_q;
  logic [I2S_OFFSET_W-1:0]  off_cnt;
  logic [I2S_BITCNT_W-1:0]  bit_cnt;
  logic [I2S_WORDCNT_W-1:0] word_cnt;
  logic [I2S_WORD_W-1:0]    sr0, sr1, sr0_n, sr1_n;
  logic                     sync_edge, offset_zero, off_last, last_bit, last_word;
  logic                     word_done, pop, drop;
  logic [1:0]               push_num, wr_num, avail, free_cnt;

  assign sync_edge   = ws_i & ~ws_q;
  assign offset_zero = (cfg_dsp_offset_i == '0);
  assign off_last    = (off_cnt == cfg_dsp_offset_i - 9'd1);
  assign last_bit    = (bit_cnt == cfg_num_bits_i);
  assign last_word   = (word_cnt == cfg_num_word_i);

  // A sync edge on the completing bit is a resync, so that word is discarded.
  assign word_done = cfg_en_i && (state == ST_RUNNING) && last_bit && !sync_edge;

  assign sr0_n = sr_insert(sr0, bit_cnt, i2s_ch0_i, cfg_lsb_first_i);
  assign sr1_n = sr_insert(sr1, bit_cnt, i2s_ch1_i, cfg_lsb_first_i);

  // A pop this cycle frees its entry before the overflow decision.
  assign pop      = fifo_data_valid_o & fifo_data_ready_i;
  assign avail    = free_cnt + {1'b0, pop};
  assign push_num = word_done ? (cfg_2ch_i ? 2'd2 : 2'd1) : 2'd0;
  assign drop     = (push_num > avail);
  assign wr_num   = drop ? 2'd0 : push_num;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    state_n = ST_WAIT_FS;
      ST_WAIT_FS: if (sync_edge) state_n = offset_zero ? ST_RUNNING : ST_OFFSET;
      ST_OFFSET: begin
        if (sync_edge)     state_n = offset_zero ? ST_RUNNING : ST_OFFSET;
        else if (off_last) state_n = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (sync_edge)                  state_n = offset_zero ? ST_RUNNING : ST_OFFSET;
        else if (last_bit && last_word) state_n = ST_WAIT_FS;
      end
      default: state_n = ST_IDLE;
    endcase
    if (!cfg_en_i) state_n = ST_IDLE;
  end

  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      ws_q  <= 1'b0;
    end else begin
      state <= state_n;
      ws_q  <= ws_i;
    end
  end

  always_ff @(posedge sck_i) begin
    if (rst_i || !cfg_en_i) begin
      off_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (sync_edge && state != ST_IDLE) begin
      off_cnt  <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (state == ST_OFFSET) begin
      off_cnt <= off_cnt + 9'd1;
    end else if (state == ST_RUNNING) begin
      if (last_bit) begin
        bit_cnt  <= '0;
        word_cnt <= last_word ? '0 : word_cnt + 4'd1;
      end else begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      sr0        <= '0;
      sr1        <= '0;
      fifo_err_o <= 1'b0;
    end else begin
      if (state == ST_RUNNING) begin
        sr0 <= sr0_n;
        sr1 <= sr1_n;
      end
      fifo_err_o <= drop;
    end
  end

  i2s_rx_word_buf u_buf (
    .clk      (sck_i),
    .rst      (rst_i),
    .flush    (!cfg_en_i),
    .wr_num   (wr_num),
    .wr_data0 (sr0_n),
    .wr_data1 (sr1_n),
    .rd_en    (fifo_data_ready_i),
    .rd_data  (fifo_data_o),
    .rd_valid (fifo_data_valid_o),
    .free_cnt (free_cnt)
  );

endmodule

// File: tb/tb_i2s_rx_dsp_channel.sv
// Self-checking bench for i2s_rx_dsp_channel: directed vector table, hand
// sequences for timing/overflow/resync/abort, and randomized frames vs a model.
module tb_i2s_rx_dsp_channel;

  logic        sck_i = 1'b0;
  logic        rst_i, ch0, ch1, ws, ready;
  logic        cfg_en, cfg_2ch, cfg_lsb_first;
  logic [4:0]  cfg_num_bits;
  logic [3:0]  cfg_num_word;
  logic [8:0]  cfg_dsp_offset;
  logic [31:0] fifo_data;
  logic        fifo_valid, fifo_err;

  i2s_rx_dsp_channel dut (
    .sck_i             (sck_i),
    .rst_i             (rst_i),
    .i2s_ch0_i         (ch0),
    .i2s_ch1_i         (ch1),
    .ws_i              (ws),
    .fifo_data_o       (fifo_data),
    .fifo_data_valid_o (fifo_valid),
    .fifo_data_ready_i (ready),
    .fifo_err_o        (fifo_err),
    .cfg_en_i          (cfg_en),
    .cfg_2ch_i         (cfg_2ch),
    .cfg_num_bits_i    (cfg_num_bits),
    .cfg_num_word_i    (cfg_num_word),
    .cfg_lsb_first_i   (cfg_lsb_first),
    .cfg_dsp_offset_i  (cfg_dsp_offset)
  );

  always #5 sck_i = ~sck_i;

  typedef struct packed {
    logic            lsb;
    logic            two;
    logic [4:0]      nb;
    logic [3:0]      nw;
    logic [8:0]      off;
    logic [1:0][31:0] d0;
    logic [1:0][31:0] d1;
    logic [3:0][31:0] exp;
    logic [2:0]      exp_n;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          err_cnt = 0;
  int          got_base, err_base;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] tx0[16];
  logic [31:0] tx1[16];
  vec_t        vecs[6];

  // Inputs change 2 time units after a rising edge, so at the falling edge
  // both the DUT outputs and the handshake inputs are settled.
  always @(negedge sck_i) begin
    if (fifo_valid && ready) got_q.push_back(fifo_data);
    if (fifo_err) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sck_i);
    #2;
  endtask

  task automatic mark();
    got_base = got_q.size();
    err_base = err_cnt;
  endtask

  task automatic configure(input logic lsb, input logic two, input logic [4:0] nb,
                           input logic [3:0] nw, input logic [8:0] off);
    cfg_en = 1'b0;
    step();
    cfg_lsb_first  = lsb;
    cfg_2ch        = two;
    cfg_num_bits   = nb;
    cfg_num_word   = nw;
    cfg_dsp_offset = off;
    step();
    cfg_en = 1'b1;
    step();
  endtask

  // Serialises bit positions first..first+count-1 of the current word order.
  task automatic send_word_bits(input logic [31:0] w0, input logic [31:0] w1,
                                input int first, input int count);
    for (int b = first; b < first + count; b++) begin
      int idx;
      idx = cfg_lsb_first ? b : int'(cfg_num_bits) - b;
      ch0 = w0[idx];
      ch1 = w1[idx];
      step();
    end
  endtask

  task automatic sync_and_offset();
    ws = 1'b1;
    step();
    ws = 1'b0;
    for (int i = 0; i < int'(cfg_dsp_offset); i++) begin
      ch0 = 1'($urandom);
      ch1 = 1'($urandom);
      step();
    end
  endtask

  task automatic send_frame();
    sync_and_offset();
    for (int w = 0; w <= int'(cfg_num_word); w++)
      send_word_bits(tx0[w], tx1[w], 0, int'(cfg_num_bits) + 1);
    ch0 = 1'b0;
    ch1 = 1'b0;
  endtask

  // Reference: each word reaches the FIFO masked to its width, ch0 before ch1.
  function automatic logic [31:0] word_mask(input logic [4:0] nb);
    logic [32:0] m;
    m = (33'd1 << (int'(nb) + 1)) - 33'd1;
    return m[31:0];
  endfunction

  task automatic build_expected();
    exp_q.delete();
    for (int w = 0; w <= int'(cfg_num_word); w++) begin
      exp_q.push_back(tx0[w] & word_mask(cfg_num_bits));
      if (cfg_2ch) exp_q.push_back(tx1[w] & word_mask(cfg_num_bits));
    end
  endtask

  task automatic compare_pops(input string tag);
    check({tag, " pop count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++)
      check($sformatf("%s word %0d", tag, i), got_q[got_base + i], exp_q[i]);
    check({tag, " err pulses"}, 32'(err_cnt - err_base), 32'd0);
  endtask

  function automatic vec_t make_vec(input logic lsb, input logic two, input logic [4:0] nb,
      input logic [3:0] nw, input logic [8:0] off,
      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] b0, input logic [31:0] b1,
      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3,
      input logic [2:0] n);
    vec_t v;
    v.lsb = lsb; v.two = two; v.nb = nb; v.nw = nw; v.off = off;
    v.d0[0] = a0; v.d0[1] = a1; v.d1[0] = b0; v.d1[1] = b1;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.exp_n = n;
    return v;
  endfunction

  // Aborts a frame mid-word by reset or by disable, then checks recovery.
  task automatic abort_mid_word(input logic use_rst, input string tag);
    configure(1'b0, 1'b0, 5'd15, 4'd0, 9'd0);
    ready = 1'b0;
    tx0[0] = 32'h0000AAAA;
    send_frame();
    step();
    check({tag, " buffered word"}, {31'd0, fifo_valid}, 32'd1);
    sync_and_offset();
    send_word_bits(32'h0000F0F0, 32'd0, 0, 8);
    if (use_rst) rst_i = 1'b1;
    else         cfg_en = 1'b0;
    step();
    check({tag, " valid after abort"}, {31'd0, fifo_valid}, 32'd0);
    check({tag, " data after abort"}, fifo_data, 32'd0);
    check({tag, " err after abort"}, {31'd0, fifo_err}, 32'd0);
    rst_i  = 1'b0;
    cfg_en = 1'b1;
    step();
    mark();
    send_word_bits(32'h00005555, 32'd0, 0, 16);
    ready = 1'b1;
    repeat (4) step();
    check({tag, " no push without sync"}, 32'(got_q.size() - got_base), 32'd0);
    tx0[0] = 32'h00001234;
    exp_q.delete();
    exp_q.push_back(32'h00001234);
    mark();
    send_frame();
    repeat (6) step();
    compare_pops({tag, " recovery"});
  endtask

  initial begin
    rst_i = 1'b1; ch0 = 1'b0; ch1 = 1'b0; ws = 1'b0; ready = 1'b0;
    cfg_en = 1'b0; cfg_2ch = 1'b0; cfg_lsb_first = 1'b0;
    cfg_num_bits = 5'd0; cfg_num_word = 4'd0; cfg_dsp_offset = 9'd0;
    for (int i = 0; i < 16; i++) begin tx0[i] = '0; tx1[i] = '0; end
    repeat (3) step();
    check("reset valid", {31'd0, fifo_valid}, 32'd0);
    check("reset data", fifo_data, 32'd0);
    check("reset err", {31'd0, fifo_err}, 32'd0);
    rst_i = 1'b0;
    step();

    vecs[0] = make_vec(1'b0, 1'b0, 5'd15, 4'd0, 9'd0, 32'h0000A5C3, 0, 0, 0,
                       32'h0000A5C3, 0, 0, 0, 3'd1);
    vecs[1] = make_vec(1'b1, 1'b1, 5'd7, 4'd1, 9'd3, 32'h12, 32'h34, 32'h56, 32'h78,
                       32'h12, 32'h56, 32'h34, 32'h78, 3'd4);
    vecs[2] = make_vec(1'b0, 1'b0, 5'd31, 4'd0, 9'd0, 32'hDEADBEEF, 0, 0, 0,
                       32'hDEADBEEF, 0, 0, 0, 3'd1);
    vecs[3] = make_vec(1'b1, 1'b0, 5'd31, 4'd0, 9'd0, 32'hDEADBEEF, 0, 0, 0,
                       32'hDEADBEEF, 0, 0, 0, 3'd1);
    vecs[4] = make_vec(1'b0, 1'b0, 5'd3, 4'd1, 9'd1, 32'hFFFFFFF5, 32'h0000000A, 0, 0,
                       32'h5, 32'hA, 0, 0, 3'd2);
    vecs[5] = make_vec(1'b0, 1'b1, 5'd1, 4'd1, 9'd2, 32'h2, 32'h1, 32'h3, 32'h0,
                       32'h2, 32'h3, 32'h1, 32'h0, 3'd4);

    for (int i = 0; i < 6; i++) begin
      configure(vecs[i].lsb, vecs[i].two, vecs[i].nb, vecs[i].nw, vecs[i].off);
      tx0[0] = vecs[i].d0[0]; tx0[1] = vecs[i].d0[1];
      tx1[0] = vecs[i].d1[0]; tx1[1] = vecs[i].d1[1];
      exp_q.delete();
      for (int k = 0; k < int'(vecs[i].exp_n); k++) exp_q.push_back(vecs[i].exp[k]);
      ready = 1'b1;
      mark();
      send_frame();
      repeat (6) step();
      compare_pops($sformatf("vec%0d", i));
    end

    // Latency and hold-until-ready on a single MSB-first word.
    configure(1'b0, 1'b0, 5'd15, 4'd0, 9'd0);
    ready = 1'b0;
    sync_and_offset();
    send_word_bits(32'h0000A5C3, 32'd0, 0, 15);
    check("latency valid before last bit", {31'd0, fifo_valid}, 32'd0);
    send_word_bits(32'h0000A5C3, 32'd0, 15, 1);
    check("latency valid after last bit", {31'd0, fifo_valid}, 32'd1);
    check("latency data", fifo_data, 32'h0000A5C3);
    repeat (3) step();
    check("hold valid", {31'd0, fifo_valid}, 32'd1);
    check("hold data", fifo_data, 32'h0000A5C3);
    mark();
    ready = 1'b1;
    step();
    check("popped valid", {31'd0, fifo_valid}, 32'd0);
    check("popped count", 32'(got_q.size() - got_base), 32'd1);

    // Overflow: a held-off FIFO keeps the first pair and drops the second.
    configure(1'b0, 1'b1, 5'd7, 4'd1, 9'd0);
    ready = 1'b0;
    tx0[0] = 32'h11; tx0[1] = 32'h22; tx1[0] = 32'h33; tx1[1] = 32'h44;
    mark();
    send_frame();
    repeat (3) step();
    check("overflow err pulses", 32'(err_cnt - err_base), 32'd1);
    check("overflow head valid", {31'd0, fifo_valid}, 32'd1);
    check("overflow head data", fifo_data, 32'h11);
    exp_q.delete();
    exp_q.push_back(32'h11);
    exp_q.push_back(32'h33);
    mark();
    ready = 1'b1;
    repeat (5) step();
    compare_pops("overflow drain");

    // Resync after 5 of 16 bits with a non-zero offset.
    configure(1'b0, 1'b0, 5'd15, 4'd0, 9'd2);
    ready = 1'b1;
    mark();
    sync_and_offset();
    send_word_bits(32'h0000FFFF, 32'd0, 0, 5);
    tx0[0] = 32'h0000BEEF;
    exp_q.delete();
    exp_q.push_back(32'h0000BEEF);
    send_frame();
    repeat (6) step();
    compare_pops("resync");

    abort_mid_word(1'b1, "reset abort");
    abort_mid_word(1'b0, "disable abort");

    for (int f = 0; f < 24; f++) begin
      logic       two, lsb;
      logic [4:0] nb;
      two = 1'($urandom);
      lsb = 1'($urandom);
      nb  = two ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
      configure(lsb, two, nb, 4'($urandom_range(0, 3)), 9'($urandom_range(0, 20)));
      for (int w = 0; w < 16; w++) begin
        tx0[w] = $urandom;
        tx1[w] = $urandom;
      end
      build_expected();
      ready = 1'b1;
      repeat ($urandom_range(0, 3)) step();
      mark();
      send_frame();
      repeat (6) step();
      compare_pops($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
